// File: rtl/mult_pkg.sv
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and default widths for the iterative 64x64
//                limb-based multiplier sequencer.
//                - state_t     : controller state encoding
//                - MULT_DATA_W : default operand width
//                - MULT_LIMB_W : default limb width
//                - MULT_NLIMB  : limbs per operand at the default widths
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_DATA_W = 64;
    localparam int MULT_LIMB_W = 16;
    localparam int MULT_NLIMB  = MULT_DATA_W / MULT_LIMB_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_seq_ctrl_64_if.sv
// ============================================================================
//  Module      : mult_seq_ctrl_64_if
//  Description : Operand / result handshake bundle for mult_seq_ctrl_64.
//                master : requesting engine + result consumer side
//                slave  : multiplier sequencer side
//                in_valid/in_ready/A/B       - operand request channel
//                out_valid/out_ready/product - result channel
//                busy                        - sequencer in MUL or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_seq_ctrl_64_if
    import mult_pkg::*;
#(
    parameter int DATA_W = MULT_DATA_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     A;
    logic [DATA_W-1:0]     B;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   product;
    logic                  busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface : mult_seq_ctrl_64_if

`default_nettype wire

// File: rtl/limb_mult_16x16.sv
// ============================================================================
//  Module      : limb_mult_16x16
//  Description : Purely combinational unsigned LIMB_W x LIMB_W multiplier.
//                Kept as its own block so the array can later be swapped for
//                a Dadda/Wallace implementation without touching the
//                sequencer.
//                i_a, i_b : LIMB_W-bit unsigned limbs
//                o_p      : 2*LIMB_W-bit product
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module limb_mult_16x16
    import mult_pkg::*;
#(
    parameter int LIMB_W = MULT_LIMB_W
) (
    input  wire logic [LIMB_W-1:0]   i_a,
    input  wire logic [LIMB_W-1:0]   i_b,
    output logic      [2*LIMB_W-1:0] o_p
);

    // Operands are zero-extended so the full double-width product is kept.
    assign o_p = {{LIMB_W{1'b0}}, i_a} * {{LIMB_W{1'b0}}, i_b};

endmodule : limb_mult_16x16

`default_nettype wire

// File: rtl/mult_seq_ctrl_64.sv
// ============================================================================
//  Module      : mult_seq_ctrl_64
//  Description : Iterative 64x64 unsigned multiplier. One limb multiplier is
//                reused over NLIMB^2 cycles; shifted limb products are summed
//                into a 2*DATA_W accumulator. Zero operands skip straight to
//                the result state.
//                clk   : rising-edge clock
//                rst_n : asynchronous active-low reset
//                bus   : slave side of mult_seq_ctrl_64_if
//                        (in_valid/in_ready/A/B, out_valid/out_ready/product,
//                         busy)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_ctrl_64
    import mult_pkg::*;
#(
    parameter int DATA_W = MULT_DATA_W,
    parameter int LIMB_W = MULT_LIMB_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mult_seq_ctrl_64_if.slave  bus
);

    localparam int NLIMB = DATA_W / LIMB_W;
    localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam int SH_W  = $clog2(2 * DATA_W);
    localparam int ACC_W = 2 * DATA_W;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NLIMB - 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [LIMB_W-1:0]   w_a_limb;
    logic [LIMB_W-1:0]   w_b_limb;
    logic [2*LIMB_W-1:0] w_limb_prod;
    logic [IDX_W:0]      w_idx_sum;
    logic [SH_W-1:0]     w_shamt;
    logic [ACC_W-1:0]    w_term;
    logic                w_accept;
    logic                w_zero_op;

    // Limb select from the captured operands.
    assign w_a_limb = r_a[r_i*LIMB_W +: LIMB_W];
    assign w_b_limb = r_b[r_j*LIMB_W +: LIMB_W];

    limb_mult_16x16 #(
        .LIMB_W (LIMB_W)
    ) u_limb_mult (
        .i_a (w_a_limb),
        .i_b (w_b_limb),
        .o_p (w_limb_prod)
    );

    // Weight of the limb product is LIMB_W*(i+j); i+j needs one extra bit.
    assign w_idx_sum = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt   = SH_W'(w_idx_sum) * SH_W'(LIMB_W);
    assign w_term    = {{(ACC_W-2*LIMB_W){1'b0}}, w_limb_prod} << w_shamt;

    // in_ready is registered and only high in IDLE, so this is the accept.
    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_zero_op = (bus.A == '0) || (bus.B == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.A;
                        r_b        <= bus.B;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_zero_op) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= MUL;
                        end
                    end
                end

                MUL: begin
                    // Sum cannot exceed 2*DATA_W bits, so no carry is kept.
                    r_acc <= r_acc + w_term;
                    if (r_j == c_last_idx) begin
                        r_j <= '0;
                        if (r_i == c_last_idx) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.product   = r_acc;

endmodule : mult_seq_ctrl_64

`default_nettype wire

// File: tb/tb_mult_seq_ctrl_64.sv
// ============================================================================
//  Module      : tb_mult_seq_ctrl_64
//  Description : Directed self-checking bench for mult_seq_ctrl_64.
//                Cycle k is observed 1 time unit after the k-th rising edge
//                following the accept; inputs change at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl_64;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    mult_seq_ctrl_64_if bus ();

    mult_seq_ctrl_64 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {in_ready, out_valid, busy}.
    function automatic logic [127:0] flags();
        return {125'd0, bus.in_ready, bus.out_valid, bus.busy};
    endfunction

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input bit zero);
        int lat;
        lat = zero ? 1 : 17;
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk({tag, "_accept_rdy"}, flags(), 128'b100);
        tick();
        bus.in_valid = 1'b0;
        // Scramble operands after acceptance; must not affect the result.
        bus.A = ~a;
        bus.B = a ^ b ^ 64'h5A5A_5A5A_5A5A_5A5A;
        for (int c = 1; c < lat; c++) begin
            chk({tag, "_mul_flags"}, flags(), 128'b001);
            tick();
        end
        chk({tag, "_done_flags"}, flags(), 128'b011);
        chk({tag, "_product"}, bus.product, exp);
        tick();
        chk({tag, "_idle_flags"}, flags(), 128'b100);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("reset_flags", flags(), 128'b100);
        chk("reset_product", bus.product, 128'd0);
        rst_n = 1'b1;
        tick();

        // out_ready while idle is ignored
        bus.out_ready = 1'b1;
        tick();
        chk("idle_out_ready", flags(), 128'b100);

        run_op("small", 64'd3, 64'd5, 128'd15, 1'b0);
        run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFFFFFFFFFFFFFE_0000000000000001, 1'b0);
        run_op("limb_bnd", 64'h0000_0000_0001_0000, 64'h0001_0000_0000_0000,
               128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0);
        run_op("mixed", 64'h0123_4567_89AB_CDEF, 64'd2,
               128'h0000_0000_0000_0000_0246_8ACF_1357_9BDE, 1'b0);
        run_op("limb2", 64'h0000_0001_0000_0000, 64'h0000_0000_0000_FFFF,
               128'h0000_0000_0000_0000_0000_FFFF_0000_0000, 1'b0);
        run_op("zeroA", 64'd0, 64'h1234, 128'd0, 1'b1);
        run_op("zeroB", 64'd7, 64'd0, 128'd0, 1'b1);

        // Backpressure: result held in cycles 17-22, released in cycle 23.
        bus.A         = 64'd10;
        bus.B         = 64'd20;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (16) tick();
        for (int c = 17; c <= 22; c++) begin
            chk("bp_flags", flags(), 128'b011);
            chk("bp_product", bus.product, 128'd200);
            if (c == 19) begin
                bus.A        = 64'd1;
                bus.B        = 64'd1;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.out_ready = 1'b1;
        chk("bp_c23_product", bus.product, 128'd200);
        tick();
        chk("bp_c24_flags", flags(), 128'b100);
        chk("bp_c24_product", bus.product, 128'd200);

        // Reset mid-operation in cycle 8.
        bus.A        = 64'hFFFF;
        bus.B        = 64'hFFFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        chk("pre_rst_flags", flags(), 128'b001);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", flags(), 128'b100);
        chk("rst_mid_product", bus.product, 128'd0);
        tick();
        chk("rst_hold_flags", flags(), 128'b100);
        rst_n = 1'b1;
        tick();
        chk("post_rst_flags", flags(), 128'b100);
        run_op("after_rst", 64'd6, 64'd7, 128'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mult_seq_ctrl_64

`default_nettype wire
